pc_redirect_ctrl: RTL

Owns the fetch PC register of the 5-stage pipeline and sequences it against three event sources: branch/jump resolution from EX (the npc_op/npc_result pair), load-use hazards from ID, and instruction-memory handshake stalls. It generates all IF/ID and ID/EX stall and flush controls. It buffers a redirect that arrives while a fetch is outstanding, so the PC presented to memory stays stable under the handshake.

---
 rtl/pc_redirect_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Owns the fetch PC of the 5-stage pipeline. It sequences the PC against
//   EX redirects, ID load-use hazards and the instruction-memory handshake,
//   and it produces the IF/ID and ID/EX stall and flush controls. A redirect
//   that arrives while a fetch is outstanding is parked in pend_q, so the PC
//   presented to memory stays stable until the handshake completes.
//
// Ports
//   cpu_clk, cpu_rst_n      clock (rising edge), async active-low reset
//   ex_valid, ex_npc_op     EX holds a real instruction / it resolved taken
//   ex_npc_result[31:0]     redirect target (bits[1:0] are ignored)
//   load_use_stall          ID hazard this cycle
//   imem_ready              imem accepts/completes the fetch at pc this cycle
//   pc[31:0], pc_valid      fetch request
//   stall_pc, stall_ifid    hold controls (combinational)
//   flush_ifid, flush_idex  bubble-insert controls (combinational)
//   misalign_err            accepted target had bit1 set (combinational pulse)
//   redirect_cnt[15:0]      saturating count of accepted redirects
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        ex_valid,
  input  logic        ex_npc_op,
  input  logic [31:0] ex_npc_result,
  input  logic        load_use_stall,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign_err,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_DROP} state_e;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [3:0]  boot_q, boot_d;
  logic [15:0] cnt_q, cnt_d;

  logic        redir;
  logic        accept;
  logic [31:0] target;
  logic [15:0] cnt_inc;

  assign redir   = ex_valid & ex_npc_op;
  assign target  = ex_npc_result & 32'hFFFF_FFFC;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    boot_d     = boot_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        // Everything held; redirects and hazards are ignored until fetch starts.
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        if (boot_q == BOOT_LAST) state_d = S_RUN;
        else                     boot_d  = boot_q + 4'd1;
      end
      S_RUN, S_WAIT: begin
        if (redir) begin
          accept     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          cnt_d      = cnt_inc;
          if (imem_ready) begin
            pc_d    = target;
            state_d = S_RUN;
          end else begin
            // Fetch still outstanding at pc: park the target, keep pc stable.
            stall_pc = 1'b1;
            pend_d   = target;
            state_d  = S_DROP;
          end
        end else if (!imem_ready) begin
          stall_pc = 1'b1;
          state_d  = S_WAIT;
          // With a load-use hazard ID must keep its instruction, so the
          // bubble goes into EX instead of ID.
          if (load_use_stall) begin
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end else begin
            flush_ifid = 1'b1;
          end
        end else if (load_use_stall) begin
          // The accepted fetch is re-issued at the same pc next cycle.
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = S_RUN;
        end else begin
          pc_d    = pc_q + 32'd4;
          state_d = S_RUN;
        end
      end
      S_DROP: begin
        // The outstanding fetch is wrong-path; whatever returns is discarded.
        flush_ifid = 1'b1;
        if (redir) begin
          accept     = 1'b1;
          flush_idex = 1'b1;
          cnt_d      = cnt_inc;
          pend_d     = target;
        end
        if (imem_ready) begin
          pc_d    = redir ? target : pend_q;
          state_d = S_RUN;
        end else begin
          stall_pc = 1'b1;
        end
      end
      default: state_d = S_BOOT;
    endcase
    misalign_err = accept & ex_npc_result[1];
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      boot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      boot_q  <= boot_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = (state_q != S_BOOT);
  assign redirect_cnt = cnt_q;

endmodule
